wb_nport_arbiter: RTL

WB_NPORT_ARBITER -- requirements
Module: wb_nport_arbiter

---
 rtl/wb_nport_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/wb_nport_arbiter.sv
// Round-robin arbiter letting NUM_CPU Wishbone masters share a single slave port.
// Optional bus-cycle watchdog enabled by defining ARB_TIMEOUT_EN.
module wb_nport_arbiter #(
  parameter int NUM_CPU = 3,
  parameter int DATA_W  = 32,
  parameter int ADR_W   = 32,
  parameter int NUM_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CPU-1:0]         m_cyc_i,
  input  logic [NUM_CPU-1:0]         m_we_i,
  input  logic [NUM_CPU*ADR_W-1:0]   m_adr_i,
  input  logic [NUM_CPU*DATA_W-1:0]  m_dat_i,
  output logic [NUM_CPU-1:0]         m_ack_o,
  output logic [NUM_CPU-1:0]         m_err_o,
  output logic [DATA_W-1:0]          m_dat_o,
  output logic [NUM_W-1:0]           cpu_num_o,
  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  output logic                       wb_we_o,
  output logic [ADR_W-1:0]           wb_adr_o,
  output logic [DATA_W-1:0]          wb_dat_o,
  input  logic [DATA_W-1:0]          wb_dat_i,
  input  logic                       wb_ack_i
);

  // state | meaning
  // IDLE  | no cycle on the slave; arbitrate among requesting masters
  // BUS   | slave cycle running for master cpu_num_o; wait for ack/abort/timeout
  // DONE  | one-cycle completion pulse on m_ack_o[cpu_num_o]
  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_W-1:0]   r_ptr;
  logic [NUM_W-1:0]   w_win;
  logic [NUM_W-1:0]   w_ptr_nxt;
  logic [NUM_W:0]     w_sum;
  logic               w_found;
  logic               w_win_we;
  logic [ADR_W-1:0]   w_win_adr;
  logic [DATA_W-1:0]  w_win_dat;
  logic [NUM_CPU-1:0] w_onehot;
  logic               w_grant;
  logic               w_abort;
  logic               w_bus_ack;
  logic               w_bus_to;
  logic               w_timeout;

  // Search from r_ptr upward with wrap; first requester found wins.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < NUM_CPU; i++) begin
      w_sum = {1'b0, r_ptr} + (NUM_W+1)'(i);
      if (w_sum >= (NUM_W+1)'(NUM_CPU))
        w_sum = w_sum - (NUM_W+1)'(NUM_CPU);
      if (!w_found && m_cyc_i[w_sum[NUM_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[NUM_W-1:0];
      end
    end
  end

  always_comb begin
    w_win_we  = 1'b0;
    w_win_adr = '0;
    w_win_dat = '0;
    for (int k = 0; k < NUM_CPU; k++) begin
      if (w_win == NUM_W'(k)) begin
        w_win_we  = m_we_i[k];
        w_win_adr = m_adr_i[k*ADR_W +: ADR_W];
        w_win_dat = m_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_onehot            = '0;
    w_onehot[cpu_num_o] = 1'b1;
  end

  assign w_ptr_nxt = (w_win == NUM_W'(NUM_CPU-1)) ? '0 : w_win + NUM_W'(1);
  assign w_grant   = (r_state == ST_IDLE) && w_found;
  // Abort outranks a same-cycle slave ack; ack outranks the watchdog.
  assign w_abort   = (r_state == ST_BUS) && !m_cyc_i[cpu_num_o];
  assign w_bus_ack = (r_state == ST_BUS) && !w_abort && wb_ack_i;
  assign w_bus_to  = (r_state == ST_BUS) && !w_abort && !wb_ack_i && w_timeout;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_state_nxt = ST_BUS;
      ST_BUS: begin
        if (w_abort)                    w_state_nxt = ST_IDLE;
        else if (w_bus_ack || w_bus_to) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      cpu_num_o <= '0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      m_ack_o   <= '0;
      m_dat_o   <= '0;
    end else begin
      m_ack_o <= '0;
      if (w_grant) begin
        r_ptr     <= w_ptr_nxt;
        cpu_num_o <= w_win;
        wb_cyc_o  <= 1'b1;
        wb_stb_o  <= 1'b1;
        wb_we_o   <= w_win_we;
        wb_adr_o  <= w_win_adr;
        wb_dat_o  <= w_win_dat;
      end
      if (w_abort || w_bus_ack || w_bus_to) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
      end
      if (w_bus_ack || w_bus_to) m_ack_o <= w_onehot;
      if (w_bus_ack) m_dat_o <= wb_dat_i;
      if (w_bus_to)  m_dat_o <= '0;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [WD_W-1:0]    r_wdog;
  logic [NUM_CPU-1:0] r_err;

  // Counter is zero on the first BUS cycle, so TIMEOUT BUS cycles elapse before the abort.
  assign w_timeout = (r_wdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog <= '0;
      r_err  <= '0;
    end else begin
      r_wdog <= (r_state == ST_BUS) ? r_wdog + WD_W'(1) : '0;
      r_err  <= w_bus_to ? w_onehot : '0;
    end
  end

  assign m_err_o = r_err;
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign m_err_o          = '0;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

endmodule
